sap_alu_regs: RTL
=================

// Module: sap_alu_regs
// PURPOSE
//   Downstream consumer of the 16-bit control word from the SAP controller: holds
//   accumulator A, B, C (swap temp), output register O, ALU and carry/zero flags.
//   Drives its share of the 8-bit W-bus and loads from it per control-word bits.
//   PC, MAR, RAM and IR stay outside; their bus traffic enters on bus_in.
// PARAMETERS
//   WIDTH   8    data/W-bus width
//   CON_W   16   control word width; field map below is fixed for 16
// PORTS
//   CLK          in   1      clock; all registers update on posedge (controller steps on negedge)
//   CLR          in   1      reset, synchronous, active-high
//   con          in   CON_W  control word, stable across each posedge
//   bus_in       in   WIDTH  W-bus value driven by PC/RAM/IR (valid when they are enabled)
//   bus_out      out  WIDTH  value this block drives onto W-bus
//   bus_drive    out  1      1 = this block owns the W-bus this cycle
//   out_reg      out  WIDTH  output register O (display)
//   carry        out  1      registered ALU carry (SUB: 1 = no borrow)
//   zero         out  1      registered ALU-result == 0
//   bus_conflict out  1      combinational: >1 bus driver enabled this cycle
// BEHAVIOUR
//   Control-word fields (n = active-low):
//     15 Cp, 14 Ep, 13 nLm, 12 nCE, 11 nLi, 10 nEi  -> external; Ep/nCE/nEi count as bus drivers
//     9 nLa, 8 Ea, 7 Eb, 6 Ec, 5:4 op (00 ADD,01 SUB,10 AND,11 OR), 3 Eu, 2 nLb, 1 nLc, 0 nLo
//   Idle word 16'h3E07 -> no loads, no drive.
//   ALU (comb. on current A,B): ADD A+B; SUB A+~B+1; AND A&B; OR A|B; 9-bit internal,
//     carry = bit WIDTH for ADD/SUB, 0 for AND/OR.
//   Bus: internal drivers Eu>Ea>Eb>Ec priority; bus_drive = Eu|Ea|Eb|Ec;
//     bus_out = selected source (ALU, A, B, C), else 0.
//   wbus = bus_drive ? bus_out : bus_in; all loads sample wbus at posedge.
//   Loads at posedge when field low: A<-wbus (nLa), B (nLb), C (nLc), O (nLo).
//     Loads use pre-edge register values (A->C and C->B same cycle legal; swap sequence
//     3F05, 3C87, 3E43 exchanges A,B).
//   Flags: updated at posedge iff Eu=1 (carry, zero of ALU result); else hold.
//   bus_conflict = (count of Eu,Ea,Eb,Ec,Ep,~nCE,~nEi) > 1; priority still applies, no state change
//     beyond normal loads.
//   Reset: CLR high at posedge -> A,B,C,O,carry,zero = 0; reset overrides any load in same cycle.
//     Outputs after reset: out_reg 0, flags 0; bus_out/bus_drive/bus_conflict follow con (comb.).
//   Latency: loaded value visible on outputs 1 cycle after the loading edge; no handshake.
//   Width: results truncate to WIDTH; wrap-around modulo 2^WIDTH (FF+01 -> 00, carry 1).
// STRUCTURE
//   sap_pkg: control-bit index constants (CON_CP..CON_NLO), ALU op codes, IDLE_CON = 16'h3E07.
//   Sub-module sap_alu: comb. op/A/B -> result, carry; instantiated once.
//   Top: field decode, bus mux + conflict count, A/B/C/O/flag registers.
// TESTING
//   Reset: preload A=B=C=O=5A, CLR=1 one edge -> all 0, carry=zero=0; con=3E07 -> bus_drive=0.
//   Load: con=2C07, bus_in=2A -> A=2A next edge, bus_drive=0; con=2E03, bus_in=17 -> B=17.
//   ADD: A=2A,B=17, con=3C0F -> A=41,c=0,z=0; A=FF,B=01 -> A=00,c=1,z=1.
//   SUB/AND/OR: A=05,B=07 3C1F -> A=FE,c=0; A=07,B=07 -> 00,c=1,z=1; A=F0,B=3C 3C2F -> 30; 3C3F -> FC.
//   SWAP/OUT: A=12,B=34, 3F05,3C87,3E43 -> A=34,B=12,C=12; then 3F06 -> out_reg=34, bus_out=34.
//   Conflict/reset-race: con=3F87 -> bus_conflict=1, bus_out=A; CLR=1 with con=3C0F -> A=0, flags 0.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg
//   Shared definitions for the SAP ALU/register slice: the bit positions of the
//   16-bit control word, the ALU operation encoding, the idle control word, and a
//   helper that counts enabled W-bus drivers.
package sap_pkg;

  // Control-word bit positions. A leading "n" in the name marks an active-low field.
  localparam int CON_CP    = 15;
  localparam int CON_EP    = 14;
  localparam int CON_NLM   = 13;
  localparam int CON_NCE   = 12;
  localparam int CON_NLI   = 11;
  localparam int CON_NEI   = 10;
  localparam int CON_NLA   = 9;
  localparam int CON_EA    = 8;
  localparam int CON_EB    = 7;
  localparam int CON_EC    = 6;
  localparam int CON_OP_HI = 5;
  localparam int CON_OP_LO = 4;
  localparam int CON_EU    = 3;
  localparam int CON_NLB   = 2;
  localparam int CON_NLC   = 1;
  localparam int CON_NLO   = 0;

  // Control word that loads nothing and drives nothing.
  localparam logic [15:0] IDLE_CON = 16'h3E07;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Number of enabled W-bus drivers among the seven possible sources.
  function automatic logic [2:0] count_drivers(input logic [6:0] en);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cnt = cnt + {2'b00, en[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sap_alu.sv
// sap_alu
//   Combinational ALU working on the current A and B register values.
//   Ports:
//     op_i      operation (ADD, SUB, AND, OR)
//     a_i, b_i  operands
//     result_o  WIDTH-bit result, wraps modulo 2^WIDTH
//     carry_o   carry out of bit WIDTH-1 for ADD/SUB (for SUB, 1 = no borrow);
//               always 0 for AND/OR
module sap_alu
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0] wide_s;

  // Compute the result one bit wider than the data path so the carry falls out of the top bit.
  always_comb begin
    wide_s = '0;
    case (op_i)
      ALU_ADD: wide_s = {1'b0, a_i} + {1'b0, b_i};
      // Two's-complement subtract: A + ~B + 1.
      ALU_SUB: wide_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
      // Logic ops leave the top bit at 0, so their carry is 0.
      ALU_AND: wide_s = {1'b0, a_i & b_i};
      ALU_OR:  wide_s = {1'b0, a_i | b_i};
      default: wide_s = '0;
    endcase
  end

  assign result_o = wide_s[WIDTH-1:0];
  assign carry_o  = wide_s[WIDTH];

endmodule

// File: rtl/sap_alu_regs.sv
// sap_alu_regs
//   Datapath slice driven by the SAP controller's control word. It holds
//   accumulator A, B, the swap temporary C, the output register O and the
//   carry/zero flags. It drives its share of the W-bus and loads from the bus.
//   Ports:
//     CLK           clock; all registers update on the rising edge
//     CLR           synchronous active-high reset; takes priority over loads
//     con           control word; must be stable across each rising edge
//     bus_in        W-bus value from the external drivers (PC/RAM/IR)
//     bus_out       value this block drives (ALU, A, B or C), else 0
//     bus_drive     1 when this block owns the W-bus
//     out_reg       output register O
//     carry, zero   registered ALU flags, updated only on cycles with Eu set
//     bus_conflict  more than one W-bus driver (internal or external) enabled
module sap_alu_regs
  import sap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CON_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [CON_W-1:0] con,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic [WIDTH-1:0] out_reg,
  output logic             carry,
  output logic             zero,
  output logic             bus_conflict
);

  // Decoded control fields. The load enables are converted to active-high here.
  logic    eu_s, ea_s, eb_s, ec_s;
  logic    ld_a_s, ld_b_s, ld_c_s, ld_o_s;
  alu_op_e op_s;

  assign eu_s   = con[CON_EU];
  assign ea_s   = con[CON_EA];
  assign eb_s   = con[CON_EB];
  assign ec_s   = con[CON_EC];
  assign ld_a_s = ~con[CON_NLA];
  assign ld_b_s = ~con[CON_NLB];
  assign ld_c_s = ~con[CON_NLC];
  assign ld_o_s = ~con[CON_NLO];
  assign op_s   = alu_op_e'(con[CON_OP_HI:CON_OP_LO]);

  // These fields belong to PC/MAR/IR and are not used by this block.
  logic unused_s;
  assign unused_s = ^{con[CON_CP], con[CON_NLM], con[CON_NLI]};

  // Registers and their next-state values.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;
  logic [WIDTH-1:0] bus_out_s;
  logic [WIDTH-1:0] wbus_s;

  sap_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_i     (op_s),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res_s),
    .carry_o  (alu_carry_s)
  );

  // Internal bus source select. If several enables are set, Eu wins, then Ea, Eb, Ec.
  always_comb begin
    bus_out_s = '0;
    if (eu_s) begin
      bus_out_s = alu_res_s;
    end else if (ea_s) begin
      bus_out_s = a_q;
    end else if (eb_s) begin
      bus_out_s = b_q;
    end else if (ec_s) begin
      bus_out_s = c_q;
    end else begin
      bus_out_s = '0;
    end
  end

  assign bus_out   = bus_out_s;
  assign bus_drive = eu_s | ea_s | eb_s | ec_s;
  assign wbus_s    = bus_drive ? bus_out_s : bus_in;

  // Ep, nCE and nEi are external drivers; they count toward a conflict but do not change the mux.
  assign bus_conflict = count_drivers({eu_s, ea_s, eb_s, ec_s, con[CON_EP],
                                       ~con[CON_NCE], ~con[CON_NEI]}) > 3'd1;

  // Next-state logic. All loads sample the bus value formed from the pre-edge register contents.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    o_d     = o_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (ld_a_s) a_d = wbus_s; else a_d = a_q;
    if (ld_b_s) b_d = wbus_s; else b_d = b_q;
    if (ld_c_s) c_d = wbus_s; else c_d = c_q;
    if (ld_o_s) o_d = wbus_s; else o_d = o_q;
    // The flags follow the ALU only on cycles where the ALU result is put on the bus.
    if (eu_s) begin
      carry_d = alu_carry_s;
      zero_d  = (alu_res_s == {WIDTH{1'b0}});
    end else begin
      carry_d = carry_q;
      zero_d  = zero_q;
    end
  end

  // State registers. The synchronous clear takes priority over any load in the same cycle.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      o_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      o_q     <= o_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign out_reg = o_q;
  assign carry   = carry_q;
  assign zero    = zero_q;

endmodule
